// File: rtl/hs32_decode2_pipe.sv
// HS32 second decode stage: operand fetch, hazard stall/forwarding and immediate shaping
// into a one-deep output register. Define HS32_D2_FWD_EN to forward results from downstream stages.
module hs32_decode2_pipe #(
  parameter int XLEN = 32,
  parameter int NHAZ = 2,
  parameter int CNTW = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [4:0]                 opc_i,
  input  logic [3:0]                 rd_i,
  input  logic [3:0]                 rm_i,
  input  logic [XLEN-1:0]            d2_i,
  input  logic [$clog2(XLEN)-1:0]    shl_i,
  input  logic [$clog2(XLEN)-1:0]    shr_i,
  input  logic                       sext_i,
  input  logic                       maskl_i,
  input  logic                       maskr_i,
  output logic [3:0]                 rp_addr_o,
  input  logic [XLEN-1:0]            rp_data_i,
  input  logic [4*NHAZ-1:0]          haz_rd_i,
  input  logic [NHAZ-1:0]            haz_vld_i,
  input  logic [NHAZ-1:0]            haz_rdy_i,
  input  logic [XLEN*NHAZ-1:0]       haz_data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            d1_o,
  output logic [XLEN-1:0]            d2_o,
  output logic [3:0]                 rd_o,
  output logic [5:0]                 ctl_o,
  input  logic                       flush_i,
  output logic [CNTW-1:0]            stall_cnt_o
);

  logic                   hazMatch;
  logic                   hazard;
  logic                   stall;
  logic                   fwdHit;
  logic                   accept;
  logic [XLEN-1:0]        srcData;

  logic                   outValid_q;
  logic [XLEN-1:0]        d1_q,   d1_d;
  logic [XLEN-1:0]        d2_q,   d2_d;
  logic [3:0]             rd_q;
  logic [5:0]             ctl_q,  ctl_d;
  logic [CNTW-1:0]        stallCnt_q;

`ifdef HS32_D2_FWD_EN
  logic                   selRdy;
  logic [XLEN-1:0]        selData;

  // Walk from the oldest stage down so the youngest matching stage is the one that sticks.
  always_comb begin
    hazMatch = 1'b0;
    selRdy   = 1'b0;
    selData  = '0;
    for (int k = NHAZ - 1; k >= 0; k--) begin
      if (haz_vld_i[k] && (haz_rd_i[4*k +: 4] == rm_i)) begin
        hazMatch = 1'b1;
        selRdy   = haz_rdy_i[k];
        selData  = haz_data_i[XLEN*k +: XLEN];
      end
    end
  end

  assign hazard  = valid_i & hazMatch;
  assign fwdHit  = hazard & selRdy;
  assign stall   = hazard & ~selRdy;
  assign srcData = fwdHit ? selData : rp_data_i;
`else
  logic unused_fwd;

  always_comb begin
    hazMatch = 1'b0;
    for (int k = 0; k < NHAZ; k++) begin
      if (haz_vld_i[k] && (haz_rd_i[4*k +: 4] == rm_i)) begin
        hazMatch = 1'b1;
      end
    end
  end

  assign hazard     = valid_i & hazMatch;
  assign fwdHit     = 1'b0;
  assign stall      = hazard;
  assign srcData    = rp_data_i;
  assign unused_fwd = ^{haz_rdy_i, haz_data_i, fwdHit};
`endif

  assign rp_addr_o = rm_i;
  assign ready_o   = (~outValid_q | ready_i) & ~stall;
  assign accept    = valid_i & ready_o;

  assign d1_d = (opc_i[4:2] == 3'b000) ? '0 : srcData;

  // Arithmetic shift is kept in its own signed net so the surrounding unsigned mux cannot demote it.
  logic signed [XLEN-1:0] d2Sra;
  logic [XLEN-1:0]        d2Shr;
  logic [XLEN-1:0]        d2Shl;

  assign d2Sra = $signed(d2_i) >>> shr_i;
  assign d2Shr = (sext_i && d2_i[XLEN-1]) ? $unsigned(d2Sra) : (d2_i >> shr_i);
  assign d2Shl = d2_i << shl_i;
  assign d2_d  = (d2Shr & {XLEN{maskr_i}}) | (d2Shl & {XLEN{maskl_i}});

  logic       alu;
  logic       ctlSub;
  logic       ctlCen;
  logic       ctlNeg;
  logic [1:0] ctlOpr;

  assign alu    = opc_i[4];
  assign ctlSub = alu & ~opc_i[2] & opc_i[1];
  assign ctlCen = alu & ~opc_i[2] & opc_i[0];
  assign ctlNeg = ctlSub | (alu & (opc_i[2:0] == 3'b101));

  always_comb begin
    ctlOpr = 2'd0;
    if (alu && opc_i[2]) begin
      if (!opc_i[1])     ctlOpr = 2'd1;
      else if (opc_i[0]) ctlOpr = 2'd3;
      else               ctlOpr = 2'd2;
    end
  end

  assign ctl_d = {opc_i[4], ctlOpr, ctlCen, ctlSub, ctlNeg};

  // Flush outranks accept and hold; data registers only move on an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      rd_q       <= '0;
      ctl_q      <= '0;
    end else if (flush_i) begin
      outValid_q <= 1'b0;
    end else if (accept) begin
      outValid_q <= 1'b1;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      rd_q       <= rd_i;
      ctl_q      <= ctl_d;
    end else if (ready_i) begin
      outValid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
    end else if (valid_i && stall && !flush_i && (stallCnt_q != {CNTW{1'b1}})) begin
      stallCnt_q <= stallCnt_q + CNTW'(1);
    end
  end

  assign valid_o     = outValid_q;
  assign d1_o        = d1_q;
  assign d2_o        = d2_q;
  assign rd_o        = rd_q;
  assign ctl_o       = ctl_q;
  assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_hs32_decode2_pipe.sv
// Self-checking bench for hs32_decode2_pipe: directed scenarios followed by random traffic
// compared against a packet-level reference model (honours HS32_D2_FWD_EN).
module tb_hs32_decode2_pipe;
  localparam int XLEN = 32;
  localparam int NHAZ = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_i, ready_o;
  logic [4:0]        opc_i;
  logic [3:0]        rd_i, rm_i;
  logic [XLEN-1:0]   d2_i;
  logic [4:0]        shl_i, shr_i;
  logic              sext_i, maskl_i, maskr_i;
  logic [3:0]        rp_addr_o;
  logic [XLEN-1:0]   rp_data_i;
  logic [4*NHAZ-1:0] haz_rd_i;
  logic [NHAZ-1:0]   haz_vld_i, haz_rdy_i;
  logic [XLEN*NHAZ-1:0] haz_data_i;
  logic              valid_o, ready_i;
  logic [XLEN-1:0]   d1_o, d2_o;
  logic [3:0]        rd_o;
  logic [5:0]        ctl_o;
  logic              flush_i;
  logic [CNTW-1:0]   stall_cnt_o;

  logic [XLEN-1:0]   regFile [16];
  assign rp_data_i = regFile[rm_i];

  int checks = 0;
  int errors = 0;

  bit          mValid = 1'b0;
  bit          mZero  = 1'b0;
  logic [31:0] mD1 = '0, mD2 = '0;
  logic [3:0]  mRd = '0;
  logic [5:0]  mCtl = '0;
  int          mCnt = 0;

  hs32_decode2_pipe #(.XLEN(XLEN), .NHAZ(NHAZ), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .opc_i(opc_i), .rd_i(rd_i), .rm_i(rm_i), .d2_i(d2_i), .shl_i(shl_i), .shr_i(shr_i),
    .sext_i(sext_i), .maskl_i(maskl_i), .maskr_i(maskr_i),
    .rp_addr_o(rp_addr_o), .rp_data_i(rp_data_i),
    .haz_rd_i(haz_rd_i), .haz_vld_i(haz_vld_i), .haz_rdy_i(haz_rdy_i), .haz_data_i(haz_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .d1_o(d1_o), .d2_o(d2_o), .rd_o(rd_o), .ctl_o(ctl_o),
    .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Right shift modelled as logical shift plus explicit sign fill.
  function automatic logic [31:0] refD2(input logic [31:0] v, input logic [4:0] sl, input logic [4:0] sr,
                                        input logic sx, input logic ml, input logic mr);
    logic [31:0] r;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    r = v >> sr;
    if (sx && v[31]) r = r | ~(ones >> sr);
    return (mr ? r : 32'h0) | (ml ? (v << sl) : 32'h0);
  endfunction

  function automatic logic [5:0] refCtl(input logic [4:0] opc);
    logic       alu, sub, cen, neg;
    logic [1:0] opr;
    alu = opc[4];
    sub = alu && (opc[2:0] inside {3'b010, 3'b011});
    cen = alu && (opc[2:0] inside {3'b001, 3'b011});
    neg = sub || (alu && opc[2:0] == 3'b101);
    case (opc[2:0])
      3'd4, 3'd5: opr = 2'd1;
      3'd6:       opr = 2'd2;
      3'd7:       opr = 2'd3;
      default:    opr = 2'd0;
    endcase
    if (!alu) opr = 2'd0;
    return {alu, opr, cen, sub, neg};
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs at the falling edge, advance the model, check registers after the rise.
  task automatic checkOutput(input string tag);
    bit          hz, rdyK, stallM, expReady;
    logic [31:0] dataK;
    @(negedge clk);
    hz = 1'b0; rdyK = 1'b0; dataK = '0;
    if (valid_i) begin
      for (int k = 0; k < NHAZ; k++) begin
        if (!hz && haz_vld_i[k] && haz_rd_i[4*k +: 4] == rm_i) begin
          hz = 1'b1; rdyK = haz_rdy_i[k]; dataK = haz_data_i[32*k +: 32];
        end
      end
    end
`ifdef HS32_D2_FWD_EN
    stallM = hz && !rdyK;
`else
    stallM = hz;
`endif
    expReady = (!mValid || ready_i) && !stallM;
    checkVal({tag, ":ready"}, 64'(ready_o), 64'(expReady));
    checkVal({tag, ":rpaddr"}, 64'(rp_addr_o), 64'(rm_i));
    if (reset) begin
      mValid = 1'b0; mZero = 1'b1; mD1 = '0; mD2 = '0; mRd = '0; mCtl = '0; mCnt = 0;
    end else begin
      if (valid_i && stallM && !flush_i && mCnt < 65535) mCnt++;
      if (flush_i) mValid = 1'b0;
      else if (valid_i && expReady) begin
        mValid = 1'b1; mZero = 1'b0;
        mD1 = (opc_i[4:2] == 3'b000) ? 32'h0 : ((hz && !stallM) ? dataK : regFile[rm_i]);
        mD2 = refD2(d2_i, shl_i, shr_i, sext_i, maskl_i, maskr_i);
        mRd = rd_i;
        mCtl = refCtl(opc_i);
      end else if (ready_i) mValid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkVal({tag, ":valid"}, 64'(valid_o), 64'(mValid));
    checkVal({tag, ":cnt"}, 64'(stall_cnt_o), 64'(mCnt));
    if (mValid || mZero) begin
      checkVal({tag, ":d1"}, 64'(d1_o), 64'(mD1));
      checkVal({tag, ":d2"}, 64'(d2_o), 64'(mD2));
      checkVal({tag, ":rd"}, 64'(rd_o), 64'(mRd));
      checkVal({tag, ":ctl"}, 64'(ctl_o), 64'(mCtl));
    end
  endtask

  task automatic applyStimulus();
    reset     = ($urandom_range(0, 49) == 0);
    valid_i   = ($urandom_range(0, 9) < 7);
    ready_i   = ($urandom_range(0, 9) < 7);
    flush_i   = ($urandom_range(0, 19) == 0);
    opc_i     = 5'($urandom);
    rd_i      = 4'($urandom);
    rm_i      = 4'($urandom_range(0, 3));
    d2_i      = $urandom;
    shl_i     = 5'($urandom);
    shr_i     = 5'($urandom);
    sext_i    = 1'($urandom);
    maskl_i   = 1'($urandom);
    maskr_i   = 1'($urandom);
    haz_vld_i = 2'($urandom);
    haz_rdy_i = 2'($urandom);
    haz_rd_i  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    haz_data_i = {$urandom, $urandom};
    regFile[$urandom_range(0, 15)] = $urandom;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regFile[i] = $urandom;
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    opc_i = '0; rd_i = '0; rm_i = '0; d2_i = '0; shl_i = '0; shr_i = '0;
    sext_i = 1'b0; maskl_i = 1'b0; maskr_i = 1'b0;
    haz_rd_i = '0; haz_vld_i = '0; haz_rdy_i = '0; haz_data_i = '0;

    checkOutput("rst0");
    checkOutput("rst1");
    checkVal("rst:valid", 64'(valid_o), 64'h0);
    checkVal("rst:ctl", 64'(ctl_o), 64'h0);
    reset = 1'b0;
    #1 checkVal("postrst:ready", 64'(ready_o), 64'h1);

    regFile[3] = 32'h10;
    valid_i = 1'b1; opc_i = 5'b10010; rd_i = 4'd7; rm_i = 4'd3;
    d2_i = 32'h8000_0000; shr_i = 5'd4; sext_i = 1'b1; maskr_i = 1'b1;
    checkOutput("basic");
    checkVal("basic:valid", 64'(valid_o), 64'h1);
    checkVal("basic:d1", 64'(d1_o), 64'h10);
    checkVal("basic:d2", 64'(d2_o), 64'hF800_0000);
    checkVal("basic:ctl", 64'(ctl_o), 64'b100011);

    rm_i = 4'd5; haz_vld_i = 2'b10; haz_rd_i = {4'd5, 4'd0}; haz_rdy_i = 2'b00;
    repeat (3) begin
      #1 checkVal("stall:ready", 64'(ready_o), 64'h0);
      checkOutput("stall");
    end
    checkVal("stall:cnt3", 64'(stall_cnt_o), 64'd3);
    haz_vld_i = 2'b00;
    #1 checkVal("unstall:ready", 64'(ready_o), 64'h1);
    checkOutput("unstall");
    checkVal("unstall:valid", 64'(valid_o), 64'h1);
    checkVal("unstall:d1", 64'(d1_o), 64'(regFile[5]));

    opc_i = 5'b10000; haz_vld_i = 2'b01; haz_rd_i = {4'd0, 4'd5}; haz_rdy_i = 2'b01;
    haz_data_i = {32'h0, 32'h0000_ABCD};
`ifdef HS32_D2_FWD_EN
    #1 checkVal("fwd:ready", 64'(ready_o), 64'h1);
    checkOutput("fwd");
    checkVal("fwd:d1", 64'(d1_o), 64'hABCD);
`else
    #1 checkVal("nofwd:ready", 64'(ready_o), 64'h0);
    checkOutput("nofwd");
    checkVal("nofwd:cnt", 64'(stall_cnt_o), 64'd4);
`endif
    haz_vld_i = 2'b00;

    sext_i = 1'b0; maskr_i = 1'b0; maskl_i = 1'b1; shl_i = 5'd0; d2_i = 32'h1234;
    checkOutput("load");
    ready_i = 1'b0; d2_i = 32'h5555;
    repeat (4) begin
      #1 checkVal("hold:ready", 64'(ready_o), 64'h0);
      checkOutput("hold");
      checkVal("hold:d2", 64'(d2_o), 64'h1234);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d2_i = 32'(i * 32'h111 + 1);
      checkOutput("stream");
      checkVal("stream:d2", 64'(d2_o), 64'(i * 32'h111 + 1));
    end

    ready_i = 1'b0; flush_i = 1'b1;
    checkOutput("flushHold");
    checkVal("flushHold:valid", 64'(valid_o), 64'h0);
    flush_i = 1'b0; ready_i = 1'b1;
    checkOutput("reload");
    flush_i = 1'b1;
    checkOutput("flushAcc");
    checkVal("flushAcc:valid", 64'(valid_o), 64'h0);
    flush_i = 1'b0;

    reset = 1'b1;
    checkOutput("satRst");
    reset = 1'b0;
    haz_vld_i = 2'b01; haz_rd_i = {4'd0, rm_i}; haz_rdy_i = 2'b00;
    repeat (65540) @(posedge clk);
    #1;
    mCnt = 65535;
    checkOutput("sat");
    checkVal("sat:cnt", 64'(stall_cnt_o), 64'hFFFF);
    haz_vld_i = 2'b00;

    repeat (400) begin
      applyStimulus();
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
